dram_cmd_scheduler: RTL and testbench
=====================================

Name: dram_cmd_scheduler

Overview:
Parametrised successor to the single-request DRAM control path. It buffers up to DEPTH host requests in order and tracks open row and timing state per bank across NBANKS flattened (BG,bank) banks. It issues ACT/PRE/RD/WR/REF/PREA commands to the PHY command port using a valid/ready handshake. It sits between the address mapper output and the command/PHY layer, replacing the single-bank command FSM plus the row-open policy.

Parameters:
NBANKS, 16, number of flattened banks (BG x bank); power of 2
ROW_W, 16, row address width
COL_W, 10, column address width
DEPTH, 8, request FIFO depth; power of 2, at least 2
T_RCD, 14, cycles from ACT to the first RD/WR on the same bank
T_RP, 14, cycles from PRE/PREA to ACT/REF
T_RAS, 32, cycles from ACT to PRE on the same bank
T_CCD, 4, minimum cycles between any two RD/WR commands
T_RFC, 160, cycles from REF until the next command

Ports:
clk  in  1  clock
nRST  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  FIFO can accept; equals !full
req_wr  in  1  1=write, 0=read
req_bank  in  $clog2(NBANKS)  flattened bank index
req_row  in  ROW_W  row address
req_col  in  COL_W  column address
cmd_valid  out  1  command presented to PHY
cmd_ready  in  1  PHY accepts the command this cycle
cmd_type  out  3  0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR, 5 REF, 6 PREA
cmd_bank  out  $clog2(NBANKS)  target bank
cmd_row  out  ROW_W  row (valid on ACT)
cmd_col  out  COL_W  column (valid on RD/WR)
rf_req  in  1  refresh request level from the timing block
rf_ack  out  1  one-cycle pulse when REF is accepted
open_mask  out  NBANKS  bit b=1 when bank b has an open row
busy  out  1  FIFO non-empty or refresh in progress

Behaviour:
- Reset (async, active-low):
  - FIFO empty; all banks closed; all timers saturated (satisfied).
  - FSM in SERVE.
  - Outputs: cmd_valid=0, cmd_type=NOP, cmd_bank/row/col=0, rf_ack=0, open_mask=0, busy=0, req_ready=1.
  - Reset mid-command discards the pending command and all queued requests.
- FIFO:
  - Push on req_valid&&req_ready.
  - Pop only when a RD/WR for the head is accepted.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - When full, req_ready=0 even if a pop occurs that cycle (no pass-through).
  - Pointers wrap modulo DEPTH.
- Handshake:
  - A command "fires" on cmd_valid&&cmd_ready.
  - Once cmd_valid=1, cmd_type/bank/row/col stay stable until fire.
  - A new command is selected only in the cycle after a fire, or while cmd_valid=0.
  - Commands are registered outputs. Minimum latency from push into an empty FIFO to cmd_valid is 2 cycles.
- Per-bank state:
  - open bit and open row.
  - act_cnt: counts up after ACT, saturates at max(T_RAS,T_RCD).
  - pre_cnt: counts up after PRE/PREA, saturates at T_RP.
- Global state: ccd_cnt counts from the last RD/WR fire, saturating at T_CCD.
- SERVE head decision, for head bank b:
  - b open, row hit, act_cnt>=T_RCD, ccd_cnt>=T_CCD: issue RD/WR.
  - b open, row miss, act_cnt>=T_RAS: issue PRE b.
  - b closed, pre_cnt>=T_RP: issue ACT b, head row.
  - Otherwise: cmd_valid=0 and wait.
  - Strictly in-order; no reordering.
- Refresh FSM (SERVE, REF_PREA, REF_RP, REF_ISSUE, REF_RFC):
  - rf_req sampled while in SERVE and no command is pending moves to REF_PREA. A pending command must complete first.
  - REF_PREA: if open_mask==0 go to REF_ISSUE once all pre_cnt>=T_RP. Otherwise wait until every open bank has act_cnt>=T_RAS, issue PREA, close all banks on fire, then go to REF_RP.
  - REF_RP: wait T_RP cycles, then REF_ISSUE.
  - REF_ISSUE: issue REF; on fire pulse rf_ack and go to REF_RFC.
  - REF_RFC: wait T_RFC cycles, then SERVE.
  - FIFO pushes continue during refresh.
- Counters are wide enough for the largest T_* parameter. Saturating counters never wrap.

Decomposition:
- dram_pkg holds: cmd_t enum (NOP..PREA, 3 bits), ref_state_t enum, and default timing constants.
- Sub-module sched_req_fifo (DEPTH, payload width) holds the FIFO.
- Per-bank tracking uses a generate loop inside the top module.

Test Plan:
- Single read, bank 3, row 0x12, col 0x40, cmd_ready=1: ACT b3 r0x12, then RD fires exactly T_RCD cycles after the ACT fire; FIFO empties; open_mask=0x0008.
- Row hit: two writes to b3 r0x12, cols 0x40 and 0x48, row already open: WR fires back-to-back with gap exactly T_CCD=4; no ACT/PRE.
- Row miss: read b3 r0x20 while r0x12 open for 5 cycles: PRE waits until act_cnt=32, then ACT 14 cycles after PRE, then RD 14 cycles after ACT.
- Backpressure: cmd_ready held 0 for 10 cycles during a pending ACT: cmd_* stable throughout; 8 pushes make req_ready=0 on the 9th; simultaneous push/pop at full keeps count=8.
- Refresh: rf_req with banks 1 and 5 open: PREA after T_RAS is met, REF T_RP cycles later, rf_ack one pulse, no command for 160 cycles, then queued requests resume with ACT.
- Reset asserted while cmd_valid=1 and FIFO holds 3 entries: all outputs return to reset values asynchronously; after release, the first command requires a new push.

Source files
------------

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared command/state types and default DRAM timing for the command scheduler
package dram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_PRE  = 3'd2,
    CMD_RD   = 3'd3,
    CMD_WR   = 3'd4,
    CMD_REF  = 3'd5,
    CMD_PREA = 3'd6
  } cmd_t;

  typedef enum logic [2:0] {
    ST_SERVE,
    ST_REF_PREA,
    ST_REF_RP,
    ST_REF_ISSUE,
    ST_REF_RFC
  } ref_state_t;

  localparam int DEF_T_RCD = 14;
  localparam int DEF_T_RP  = 14;
  localparam int DEF_T_RAS = 32;
  localparam int DEF_T_CCD = 4;
  localparam int DEF_T_RFC = 160;

  // Fire-to-fire distance of the quickest follow-up command: select one cycle, present the next.
  localparam int CMD_LAT = 2;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sched_req_fifo.sv
// rtl/sched_req_fifo.sv - in-order request FIFO; push is refused when full even if a pop coincides
module sched_req_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// rtl/dram_cmd_scheduler.sv - in-order multi-bank DRAM command scheduler with refresh sequencing
module dram_cmd_scheduler
  import dram_pkg::*;
#(
  parameter int NBANKS = 16,
  parameter int ROW_W  = 16,
  parameter int COL_W  = 10,
  parameter int DEPTH  = 8,
  parameter int T_RCD  = DEF_T_RCD,
  parameter int T_RP   = DEF_T_RP,
  parameter int T_RAS  = DEF_T_RAS,
  parameter int T_CCD  = DEF_T_CCD,
  parameter int T_RFC  = DEF_T_RFC
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [$clog2(NBANKS)-1:0] req_bank,
  input  logic [ROW_W-1:0]          req_row,
  input  logic [COL_W-1:0]          req_col,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [2:0]                cmd_type,
  output logic [$clog2(NBANKS)-1:0] cmd_bank,
  output logic [ROW_W-1:0]          cmd_row,
  output logic [COL_W-1:0]          cmd_col,
  input  logic                      rf_req,
  output logic                      rf_ack,
  output logic [NBANKS-1:0]         open_mask,
  output logic                      busy
);
  localparam int BW   = $clog2(NBANKS);
  localparam int TMAX = max_of(max_of(max_of(T_RCD, T_RP), max_of(T_RAS, T_CCD)), max_of(T_RFC, CMD_LAT));
  localparam int CW   = $clog2(TMAX + 1);
  localparam int PW   = 1 + BW + ROW_W + COL_W;

  // Counters hold the fire distance a command selected now would achieve, hence the CMD_LAT preload.
  localparam logic [CW-1:0] RCD_C   = CW'(T_RCD);
  localparam logic [CW-1:0] RP_C    = CW'(T_RP);
  localparam logic [CW-1:0] RAS_C   = CW'(T_RAS);
  localparam logic [CW-1:0] CCD_C   = CW'(T_CCD);
  localparam logic [CW-1:0] RFC_C   = CW'(T_RFC);
  localparam logic [CW-1:0] LAT_C   = CW'(CMD_LAT);
  localparam logic [CW-1:0] TMAX_C  = CW'(TMAX);
  localparam logic [CW-1:0] ACT_SAT = CW'(max_of(T_RAS, T_RCD));

  ref_state_t         st_q, st_d;
  logic               cmd_valid_q;
  cmd_t               cmd_type_q, nxt_type;
  logic [BW-1:0]      cmd_bank_q, nxt_bank;
  logic [ROW_W-1:0]   cmd_row_q, nxt_row;
  logic [COL_W-1:0]   cmd_col_q, nxt_col;
  logic [CW-1:0]      ccd_cnt_q, tmr_q;
  logic               fire, load, serve, pop, fifo_full, fifo_empty;
  logic [PW-1:0]      fifo_dout;
  logic               h_wr;
  logic [BW-1:0]      h_bank;
  logic [ROW_W-1:0]   h_row;
  logic [COL_W-1:0]   h_col;
  logic [NBANKS-1:0]  open_v, ras_ok, rp_ok;
  logic [ROW_W-1:0]   bank_row [NBANKS];
  logic [CW-1:0]      act_cnt  [NBANKS];
  logic [CW-1:0]      pre_cnt  [NBANKS];

  assign fire      = cmd_valid_q && cmd_ready;
  assign pop       = fire && ((cmd_type_q == CMD_RD) || (cmd_type_q == CMD_WR));
  assign req_ready = !fifo_full;
  assign {h_wr, h_bank, h_row, h_col} = fifo_dout;

  sched_req_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk   (clk),
    .nRST  (nRST),
    .push  (req_valid),
    .din   ({req_wr, req_bank, req_row, req_col}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic             open_b_q;
    logic [ROW_W-1:0] row_b_q;
    logic [CW-1:0]    act_b_q, pre_b_q;
    logic             sel_b;

    assign sel_b = (cmd_bank_q == BW'(b));

    always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
        open_b_q <= 1'b0;
        row_b_q  <= '0;
        act_b_q  <= ACT_SAT;
        pre_b_q  <= RP_C;
      end else begin
        if (fire && sel_b && (cmd_type_q == CMD_ACT)) begin
          open_b_q <= 1'b1;
          row_b_q  <= cmd_row_q;
          act_b_q  <= LAT_C;
        end else if (act_b_q < ACT_SAT) begin
          act_b_q <= act_b_q + CW'(1);
        end
        if (fire && ((sel_b && (cmd_type_q == CMD_PRE)) || (cmd_type_q == CMD_PREA))) begin
          open_b_q <= 1'b0;
          pre_b_q  <= LAT_C;
        end else if (pre_b_q < RP_C) begin
          pre_b_q <= pre_b_q + CW'(1);
        end
      end
    end

    assign open_v[b]   = open_b_q;
    assign bank_row[b] = row_b_q;
    assign act_cnt[b]  = act_b_q;
    assign pre_cnt[b]  = pre_b_q;
    assign ras_ok[b]   = !open_b_q || (act_b_q >= RAS_C);
    assign rp_ok[b]    = (pre_b_q >= RP_C);
  end

  always_comb begin
    st_d     = st_q;
    load     = 1'b0;
    serve    = 1'b0;
    nxt_type = CMD_NOP;
    nxt_bank = '0;
    nxt_row  = '0;
    nxt_col  = '0;
    case (st_q)
      ST_SERVE: serve = 1'b1;
      ST_REF_PREA: begin
        if (cmd_valid_q) begin
          if (fire) st_d = ST_REF_RP;
        end else if (open_v == '0) begin
          if (&rp_ok) begin
            load     = 1'b1;
            nxt_type = CMD_REF;
            st_d     = ST_REF_ISSUE;
          end
        end else if (&ras_ok) begin
          load     = 1'b1;
          nxt_type = CMD_PREA;
        end
      end
      ST_REF_RP: begin
        if (tmr_q >= RP_C) begin
          load     = 1'b1;
          nxt_type = CMD_REF;
          st_d     = ST_REF_ISSUE;
        end
      end
      ST_REF_ISSUE: if (fire) st_d = ST_REF_RFC;
      ST_REF_RFC: begin
        if (tmr_q >= RFC_C) begin
          st_d  = ST_SERVE;
          serve = 1'b1;
        end
      end
      default: st_d = ST_SERVE;
    endcase

    // Strictly in-order: only the FIFO head is ever considered.
    if (serve && !cmd_valid_q) begin
      if ((st_q == ST_SERVE) && rf_req) begin
        st_d = ST_REF_PREA;
      end else if (!fifo_empty) begin
        nxt_bank = h_bank;
        if (open_v[h_bank]) begin
          if (bank_row[h_bank] == h_row) begin
            if ((act_cnt[h_bank] >= RCD_C) && (ccd_cnt_q >= CCD_C)) begin
              load     = 1'b1;
              nxt_type = h_wr ? CMD_WR : CMD_RD;
              nxt_col  = h_col;
            end
          end else if (act_cnt[h_bank] >= RAS_C) begin
            load     = 1'b1;
            nxt_type = CMD_PRE;
          end
        end else if (pre_cnt[h_bank] >= RP_C) begin
          load     = 1'b1;
          nxt_type = CMD_ACT;
          nxt_row  = h_row;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      st_q        <= ST_SERVE;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_NOP;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      ccd_cnt_q   <= CCD_C;
      tmr_q       <= TMAX_C;
    end else begin
      st_q <= st_d;
      if (fire) begin
        cmd_valid_q <= 1'b0;
        cmd_type_q  <= CMD_NOP;
      end else if (load && !cmd_valid_q) begin
        cmd_valid_q <= 1'b1;
        cmd_type_q  <= nxt_type;
        cmd_bank_q  <= nxt_bank;
        cmd_row_q   <= nxt_row;
        cmd_col_q   <= nxt_col;
      end
      if (pop) ccd_cnt_q <= LAT_C;
      else if (ccd_cnt_q < CCD_C) ccd_cnt_q <= ccd_cnt_q + CW'(1);
      if (fire && ((cmd_type_q == CMD_PREA) || (cmd_type_q == CMD_REF))) tmr_q <= LAT_C;
      else if (tmr_q < TMAX_C) tmr_q <= tmr_q + CW'(1);
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign rf_ack    = fire && (cmd_type_q == CMD_REF);
  assign open_mask = open_v;
  assign busy      = !fifo_empty || (st_q != ST_SERVE);

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb/tb_dram_cmd_scheduler.sv - directed self-checking bench for dram_cmd_scheduler
module tb_dram_cmd_scheduler;
  logic        clk = 1'b0;
  logic        nRST;
  logic        req_valid, req_ready, req_wr;
  logic [3:0]  req_bank;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_type;
  logic [3:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        rf_req, rf_ack;
  logic [15:0] open_mask;
  logic        busy;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int rf_ack_cnt = 0;
  int f_type[$], f_bank[$], f_row[$], f_col[$], f_cyc[$], f_rdy[$];

  dram_cmd_scheduler dut (
    .clk(clk), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .rf_req(rf_req), .rf_ack(rf_ack), .open_mask(open_mask), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every fire half a cycle before the edge that accepts it.
  always @(negedge clk) begin
    if (nRST) begin
      if (cmd_valid && cmd_ready) begin
        f_type.push_back(int'(cmd_type));
        f_bank.push_back(int'(cmd_bank));
        f_row.push_back(int'(cmd_row));
        f_col.push_back(int'(cmd_col));
        f_cyc.push_back(cyc);
        f_rdy.push_back(int'(req_ready));
      end
      if (rf_ack) rf_ack_cnt <= rf_ack_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    f_type.delete(); f_bank.delete(); f_row.delete();
    f_col.delete();  f_cyc.delete();  f_rdy.delete();
    rf_ack_cnt = 0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick(2);
    nRST = 1'b1;
    tick(1);
    clear_log();
  endtask

  task automatic push(input logic wr, input int bank, input int row, input int col);
    logic rdy;
    int budget;
    budget = 200;
    rdy = 1'b0;
    req_valid = 1'b1; req_wr = wr;
    req_bank = 4'(bank); req_row = 16'(row); req_col = 10'(col);
    while (!rdy && budget > 0) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    req_valid = 1'b0;
    if (!rdy) check_val("push_timeout", 0, 1);
  endtask

  task automatic wait_fires(input int n, input int budget);
    int b;
    b = budget;
    while (f_type.size() < n && b > 0) begin
      tick(1);
      b--;
    end
    check_val("fire_count", f_type.size(), n);
  endtask

  initial begin
    int unstable;
    int wait_b;
    nRST = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_bank = '0; req_row = '0; req_col = '0;
    cmd_ready = 1'b1; rf_req = 1'b0;
    tick(2);
    check_val("rst_cmd_valid", cmd_valid, 0);
    check_val("rst_cmd_type", cmd_type, 0);
    check_val("rst_open_mask", open_mask, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_rf_ack", rf_ack, 0);
    nRST = 1'b1;
    tick(1);
    clear_log();

    // Single read, bank 3
    req_valid = 1'b1; req_wr = 1'b0; req_bank = 4'd3; req_row = 16'h12; req_col = 10'h40;
    tick(1);
    req_valid = 1'b0;
    check_val("lat_cycle1", cmd_valid, 0);
    tick(1);
    check_val("lat_cycle2", cmd_valid, 1);
    wait_fires(2, 100);
    if (f_type.size() == 2) begin
      check_val("rd1_act_type", f_type[0], 1);
      check_val("rd1_act_bank", f_bank[0], 3);
      check_val("rd1_act_row", f_row[0], 'h12);
      check_val("rd1_rd_type", f_type[1], 3);
      check_val("rd1_rd_col", f_col[1], 'h40);
      check_val("rd1_trcd_gap", f_cyc[1] - f_cyc[0], 14);
    end
    tick(2);
    check_val("rd1_open_mask", open_mask, 'h0008);
    check_val("rd1_busy", busy, 0);

    // Row hit: two writes
    clear_log();
    push(1'b1, 3, 'h12, 'h40);
    push(1'b1, 3, 'h12, 'h48);
    wait_fires(2, 100);
    tick(10);
    check_val("hit_no_extra", f_type.size(), 2);
    if (f_type.size() == 2) begin
      check_val("hit_wr0_type", f_type[0], 4);
      check_val("hit_wr1_type", f_type[1], 4);
      check_val("hit_wr0_col", f_col[0], 'h40);
      check_val("hit_wr1_col", f_col[1], 'h48);
      check_val("hit_tccd_gap", f_cyc[1] - f_cyc[0], 4);
    end

    // Row miss behind a freshly opened row
    do_reset();
    push(1'b0, 3, 'h12, 'h40);
    push(1'b0, 3, 'h20, 'h44);
    wait_fires(5, 300);
    if (f_type.size() == 5) begin
      check_val("miss_seq2", f_type[2], 2);
      check_val("miss_seq3", f_type[3], 1);
      check_val("miss_seq4", f_type[4], 3);
      check_val("miss_tras_gap", f_cyc[2] - f_cyc[0], 32);
      check_val("miss_trp_gap", f_cyc[3] - f_cyc[2], 14);
      check_val("miss_trcd_gap", f_cyc[4] - f_cyc[3], 14);
      check_val("miss_act_row", f_row[3], 'h20);
      check_val("miss_rd_col", f_col[4], 'h44);
    end
    check_val("miss_open_mask", open_mask, 'h0008);

    // Backpressure and full FIFO
    do_reset();
    cmd_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(1'b0, 2, 1, i);
    check_val("bp_ready_at7", req_ready, 1);
    push(1'b0, 2, 1, 7);
    check_val("bp_ready_at8", req_ready, 0);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(cmd_valid === 1'b1 && cmd_type === 3'd1 && cmd_bank === 4'd2 && cmd_row === 16'd1))
        unstable++;
    end
    check_val("bp_stable", unstable, 0);
    tick(1);
    cmd_ready = 1'b1;
    push(1'b0, 2, 1, 8);
    wait_fires(10, 200);
    if (f_type.size() == 10) begin
      check_val("bp_no_passthru", f_rdy[1], 0);
      for (int i = 0; i < 9; i++) check_val("bp_rd_col", f_col[i+1], i);
      check_val("bp_rd_gap", f_cyc[2] - f_cyc[1], 4);
    end

    // Refresh with banks 1 and 5 open
    do_reset();
    push(1'b0, 1, 5, 0);
    push(1'b0, 5, 6, 1);
    wait_fires(4, 200);
    rf_req = 1'b1;
    push(1'b0, 1, 5, 3);
    wait_b = 300;
    while (rf_ack_cnt == 0 && wait_b > 0) begin
      tick(1);
      wait_b--;
    end
    rf_req = 1'b0;
    wait_fires(8, 400);
    if (f_type.size() == 8) begin
      check_val("ref_prea_type", f_type[4], 6);
      check_val("ref_prea_tras", f_cyc[4] - f_cyc[2], 32);
      check_val("ref_ref_type", f_type[5], 5);
      check_val("ref_trp_gap", f_cyc[5] - f_cyc[4], 14);
      check_val("ref_resume_type", f_type[6], 1);
      check_val("ref_resume_bank", f_bank[6], 1);
      check_val("ref_trfc_gap", f_cyc[6] - f_cyc[5], 160);
      check_val("ref_rd_col", f_col[7], 3);
    end
    check_val("ref_ack_pulses", rf_ack_cnt, 1);
    tick(2);
    check_val("ref_open_mask", open_mask, 'h0002);

    // Reset mid-command with queued requests
    do_reset();
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 4, 7, i);
    tick(1);
    check_val("mr_pending", cmd_valid, 1);
    check_val("mr_busy_before", busy, 1);
    #2;
    nRST = 1'b0;
    #1;
    check_val("mr_cmd_valid", cmd_valid, 0);
    check_val("mr_cmd_type", cmd_type, 0);
    check_val("mr_cmd_bank", cmd_bank, 0);
    check_val("mr_cmd_row", cmd_row, 0);
    check_val("mr_busy", busy, 0);
    check_val("mr_req_ready", req_ready, 1);
    tick(2);
    clear_log();
    nRST = 1'b1;
    cmd_ready = 1'b1;
    tick(20);
    check_val("mr_no_cmd", f_type.size(), 0);
    check_val("mr_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
